load_store_unit: RTL

MEM-stage load/store unit between the pipeline's execute/memory register and the byte-addressed data memory. The data memory has a combinational read port and a masked synchronous write port. This unit:
- accepts load/store requests with a valid/ready handshake;
- checks alignment and funct3 legality;
- buffers stores in a small FIFO store buffer that drains over the single shared memory port;
- returns sign/zero-extended load data one cycle after acceptance.

---
 rtl/load_store_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit (valid/ready request in; registered load rsp and exc pulse out; FIFO store buffer draining to a masked-write dmem port; sb_empty for fence)
module load_store_unit #(
  parameter int SB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        exc_valid,
  output logic        exc_cause,
  output logic [31:0] exc_addr,
  output logic        sb_empty,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_write_data,
  output logic        dmem_write_enable,
  output logic [3:0]  dmem_write_mask,
  input  logic [31:0] dmem_read_data
);
  localparam int AW = $clog2(SB_DEPTH);
  logic [31:0] sb_addr [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [3:0]  sb_mask [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_v;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic illegal, misaligned, exc, full, conflict, load_acc, store_acc, drain;
  logic [31:0] ext;
  always_comb begin
    illegal = req_is_store ? req_funct3[2] | (&req_funct3[1:0]) : req_funct3[1] & (req_funct3[0] | req_funct3[2]);
    misaligned = (req_funct3[1:0] == 2'b01 & req_addr[0]) | (req_funct3[1:0] == 2'b10 & |req_addr[1:0]);
    exc = illegal | misaligned;
    full = count == (AW+1)'(SB_DEPTH);
    sb_empty = count == '0;
    conflict = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) conflict = conflict | (sb_v[i] & (sb_addr[i][31:2] == req_addr[31:2]));
    req_ready = exc | (req_is_store ? !full : !conflict);
    load_acc = req_valid & !req_is_store & !exc & !conflict;
    store_acc = req_valid & req_is_store & !exc & !full;
    drain = rst_n & !load_acc & !sb_empty;
    dmem_address = load_acc ? req_addr : drain ? sb_addr[rd_ptr] : '0;
    dmem_write_data = drain ? sb_data[rd_ptr] : '0;
    dmem_write_mask = drain ? sb_mask[rd_ptr] : '0;
    dmem_write_enable = drain;
    ext = req_funct3[1] ? dmem_read_data :
          req_funct3[0] ? {{16{~req_funct3[2] & dmem_read_data[15]}}, dmem_read_data[15:0]} :
                          {{24{~req_funct3[2] & dmem_read_data[7]}}, dmem_read_data[7:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_v <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_rd <= '0;
      exc_valid <= 1'b0;
      exc_cause <= 1'b0;
      exc_addr <= '0;
    end else begin
      if (store_acc) begin
        sb_addr[wr_ptr] <= req_addr;
        sb_data[wr_ptr] <= req_wdata;
        sb_mask[wr_ptr] <= req_funct3[1] ? 4'b1111 : req_funct3[0] ? 4'b0011 : 4'b0001;
        sb_v[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (drain) begin
        sb_v[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(store_acc) - (AW+1)'(drain);
      rsp_valid <= load_acc;
      if (load_acc) begin
        rsp_data <= ext;
        rsp_rd <= req_rd;
      end
      exc_valid <= req_valid & exc;
      if (req_valid & exc) begin
        exc_cause <= illegal;
        exc_addr <= req_addr;
      end
    end
  end
endmodule
